hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL provide: clk  input  1  pipeline clock; all state updates on its rising edge.
REQ-002 SHALL provide: reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-003 SHALL provide: rs_IF_ID  input  5  rs field of the instruction in decode.
REQ-004 SHALL provide: rt_IF_ID  input  5  rt field of the instruction in decode.
REQ-005 SHALL provide: tuse_rs / tuse_rt  input  2 each  cycles until the operand is consumed: 0 = ID (beq, jr), 1 = EX, 2 = MEM (sw data), 3 = unused.
REQ-006 SHALL provide: rd_ID  input  5  destination register of the decode instruction.
REQ-007 SHALL provide: we_ID  input  1  decode instruction writes the register file.
REQ-008 SHALL provide: tnew_ID  input  2  cycles after entering EX until the result is forwardable: ALU/lui = 1, load = 2, none = 0.
REQ-009 SHALL provide: rd_ID_EX, rd_EX_MEM, rd_MEM_WB  output  5 each  registered destination per stage; this is the interface the forwarding unit consumes.
REQ-010 SHALL provide: we_ID_EX, we_EX_MEM, we_MEM_WB  output  1 each  registered write enable per stage.
REQ-011 SHALL provide: stall  output  1  combinational; freezes PC and IF/ID.
REQ-012 SHALL provide: bubble  output  1  combinational; equals stall; clears the datapath ID/EX register.
REQ-013 SHALL provide: stall_cnt  output  32  registered count of stalled cycles.

Function
REQ-014 SHALL hold three stage records {rd, we, tnew}: ID/EX, EX/MEM, MEM/WB.
REQ-015 SHALL normalise on capture: rd_ID = 0 stores we = 0; we_ID = 0 stores rd = 0, tnew = 0.
REQ-016 SHALL, per cycle without stall: ID/EX <= normalised decode record; EX/MEM <= ID/EX; MEM/WB <= EX/MEM.
REQ-017 SHALL decrement tnew by 1 on each stage advance, saturating at 0.
REQ-018 SHALL, on stall: load ID/EX with bubble {0,0,0}; EX/MEM and MEM/WB still advance.
REQ-019 SHALL assert stall for rs when rs != 0, tuse_rs != 3, and (we_ID_EX, rd_ID_EX == rs, tnew_ID_EX > tuse_rs) or (we_EX_MEM, rd_EX_MEM == rs, tnew_EX_MEM > tuse_rs); same rule for rt; stall = OR of both.
REQ-020 SHALL never stall on MEM/WB (tnew there is always 0).
REQ-021 SHALL compare tnew against tuse as 2-bit unsigned values.
REQ-022 SHALL increment stall_cnt each stalled cycle, wrapping 0xFFFFFFFF -> 0.
REQ-023 SHALL resolve a simultaneous rs and rt hazard as one stall cycle, counted once.

Reset
REQ-024 SHALL clear, on reset, all stage records to {0,0,0} and stall_cnt to 0; all we outputs read 0 in the following cycle.
REQ-025 SHALL force stall = 0 while reset is high; a reset during a stall discards the hazard and does not count the cycle.

Structure
REQ-026 SHALL place REG_W = 5, TUSE_NONE = 3, TNEW_ALU = 1, TNEW_LOAD = 2 and the stage-record layout in the shared pipeline package.
REQ-027 SHALL implement each stage record as one sub-module, dest_stage: clk, reset, clear, input record, output record with saturating tnew decrement; instantiate it three times.

Verification
REQ-028 SHALL verify load-use: lw $8 enters EX (tnew 2); the next instruction has rs = 8, tuse 1 -> stall = 1 for exactly 1 cycle, rd_EX_MEM = 8 next cycle, stall_cnt = 1.
REQ-029 SHALL verify branch after ALU: addu $3 in EX (tnew 1); beq with rs = 3, tuse 0 -> 1 stall cycle; after the ALU reaches MEM, stall = 0.
REQ-030 SHALL verify branch after load: lw $5 in EX; beq with rt = 5, tuse 0 -> 2 consecutive stall cycles, stall_cnt = 2.
REQ-031 SHALL verify store data: lw $6 in EX; sw with rt = 6, tuse 2 -> no stall; we_EX_MEM = 1 and rd_EX_MEM = 6 next cycle.
REQ-032 SHALL verify $0 and reset: lw $0, then rs = 0 -> no stall, we_ID_EX = 0; reset asserted mid-stall -> next cycle all rd/we = 0, stall_cnt = 0.
REQ-033 SHALL verify wrap: stall_cnt preloaded to 0xFFFFFFFF via force, one stall -> 0.

Source files
------------

// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions for the hazard controller: register width,
// tuse/tnew encodings, the per-stage destination record and helper functions.
package hazard_ctrl_pkg;

    localparam int REG_W = 5;

    localparam logic [1:0] TUSE_NONE = 2'd3;
    localparam logic [1:0] TNEW_NONE = 2'd0;
    localparam logic [1:0] TNEW_ALU  = 2'd1;
    localparam logic [1:0] TNEW_LOAD = 2'd2;

    typedef struct packed {
        logic [REG_W-1:0] rd;
        logic             we;
        logic [1:0]       tnew;
    } stage_rec_t;

    localparam stage_rec_t REC_EMPTY = '{rd: 5'd0, we: 1'b0, tnew: 2'd0};

    // $0 is never a real destination, and a non-writer carries no destination.
    function automatic stage_rec_t normalise_rec(input logic [REG_W-1:0] rd,
                                                 input logic             we,
                                                 input logic [1:0]       tnew);
        stage_rec_t r;
        if (!we) begin
            r = REC_EMPTY;
        end else if (rd == 5'd0) begin
            r = '{rd: 5'd0, we: 1'b0, tnew: tnew};
        end else begin
            r = '{rd: rd, we: 1'b1, tnew: tnew};
        end
        return r;
    endfunction

    function automatic logic [1:0] tnew_dec(input logic [1:0] tnew);
        logic [1:0] t;
        if (tnew == 2'd0) begin
            t = 2'd0;
        end else begin
            t = tnew - 2'd1;
        end
        return t;
    endfunction

    // A source hazards against a stage when the producer's result is not ready
    // by the time the consumer needs it.
    function automatic logic hazard_on(input logic [REG_W-1:0] src,
                                       input logic [1:0]       tuse,
                                       input stage_rec_t       rec);
        return (src != 5'd0) && (tuse != TUSE_NONE) && rec.we &&
               (rec.rd == src) && (rec.tnew > tuse);
    endfunction

endpackage

// File: rtl/hazard_ctrl_dest_stage.sv
// One pipeline destination record {rd, we, tnew}; optionally decrements tnew
// (saturating) as the record advances into this stage.
module dest_stage
    import hazard_ctrl_pkg::*;
#(
    parameter bit DEC_ON_CAPTURE = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [REG_W-1:0] rd_i,
    input  logic             we_i,
    input  logic [1:0]       tnew_i,
    output logic [REG_W-1:0] rd_o,
    output logic             we_o,
    output logic [1:0]       tnew_o
);

    stage_rec_t rec_d;
    stage_rec_t rec_q;

    // Next record: bubble on clear, otherwise the incoming record aged by one stage.
    always_comb begin
        rec_d = REC_EMPTY;
        if (clear) begin
            rec_d = REC_EMPTY;
        end else if (DEC_ON_CAPTURE) begin
            rec_d = '{rd: rd_i, we: we_i, tnew: tnew_dec(tnew_i)};
        end else begin
            rec_d = '{rd: rd_i, we: we_i, tnew: tnew_i};
        end
    end

    // Stage record register.
    always_ff @(posedge clk) begin
        if (reset) begin
            rec_q <= REC_EMPTY;
        end else begin
            rec_q <= rec_d;
        end
    end

    assign rd_o   = rec_q.rd;
    assign we_o   = rec_q.we;
    assign tnew_o = rec_q.tnew;

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use / branch hazard detection: tracks destinations of the three stages
// past decode and stalls decode when an operand cannot be forwarded in time.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rs_IF_ID,
    input  logic [4:0]  rt_IF_ID,
    input  logic [1:0]  tuse_rs,
    input  logic [1:0]  tuse_rt,
    input  logic [4:0]  rd_ID,
    input  logic        we_ID,
    input  logic [1:0]  tnew_ID,
    output logic [4:0]  rd_ID_EX,
    output logic [4:0]  rd_EX_MEM,
    output logic [4:0]  rd_MEM_WB,
    output logic        we_ID_EX,
    output logic        we_EX_MEM,
    output logic        we_MEM_WB,
    output logic        stall,
    output logic        bubble,
    output logic [31:0] stall_cnt
);

    stage_rec_t dec_rec;
    stage_rec_t idex_rec;
    stage_rec_t exmem_rec;
    stage_rec_t memwb_rec;
    logic       rs_haz;
    logic       rt_haz;
    logic       stall_int;
    logic [31:0] stall_cnt_d;
    logic [31:0] stall_cnt_q;

    assign dec_rec = normalise_rec(rd_ID, we_ID, tnew_ID);

    // ID/EX keeps the decode tnew as-is; later stages age it on each advance.
    dest_stage #(.DEC_ON_CAPTURE(1'b0)) u_id_ex (
        .clk    (clk),
        .reset  (reset),
        .clear  (stall_int),
        .rd_i   (dec_rec.rd),
        .we_i   (dec_rec.we),
        .tnew_i (dec_rec.tnew),
        .rd_o   (idex_rec.rd),
        .we_o   (idex_rec.we),
        .tnew_o (idex_rec.tnew)
    );

    dest_stage #(.DEC_ON_CAPTURE(1'b1)) u_ex_mem (
        .clk    (clk),
        .reset  (reset),
        .clear  (1'b0),
        .rd_i   (idex_rec.rd),
        .we_i   (idex_rec.we),
        .tnew_i (idex_rec.tnew),
        .rd_o   (exmem_rec.rd),
        .we_o   (exmem_rec.we),
        .tnew_o (exmem_rec.tnew)
    );

    dest_stage #(.DEC_ON_CAPTURE(1'b1)) u_mem_wb (
        .clk    (clk),
        .reset  (reset),
        .clear  (1'b0),
        .rd_i   (exmem_rec.rd),
        .we_i   (exmem_rec.we),
        .tnew_i (exmem_rec.tnew),
        .rd_o   (memwb_rec.rd),
        .we_o   (memwb_rec.we),
        .tnew_o (memwb_rec.tnew)
    );

    // Hazard detection; MEM/WB always carries tnew 0, so its term can never fire.
    always_comb begin
        rs_haz = hazard_on(rs_IF_ID, tuse_rs, idex_rec)  |
                 hazard_on(rs_IF_ID, tuse_rs, exmem_rec) |
                 hazard_on(rs_IF_ID, tuse_rs, memwb_rec);
        rt_haz = hazard_on(rt_IF_ID, tuse_rt, idex_rec)  |
                 hazard_on(rt_IF_ID, tuse_rt, exmem_rec) |
                 hazard_on(rt_IF_ID, tuse_rt, memwb_rec);
        if (reset) begin
            stall_int = 1'b0;
        end else begin
            stall_int = rs_haz | rt_haz;
        end
    end

    // Stall counter next value; one increment per stalled cycle, wraps naturally.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (reset) begin
            stall_cnt_d = 32'd0;
        end else if (stall_int) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt_q <= 32'd0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall     = stall_int;
    assign bubble    = stall_int;
    assign stall_cnt = stall_cnt_q;
    assign rd_ID_EX  = idex_rec.rd;
    assign rd_EX_MEM = exmem_rec.rd;
    assign rd_MEM_WB = memwb_rec.rd;
    assign we_ID_EX  = idex_rec.we;
    assign we_EX_MEM = exmem_rec.we;
    assign we_MEM_WB = memwb_rec.we;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: each step drives decode inputs, queues the
// hand-derived expected outputs and checks them before the next rising edge.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  rs_IF_ID = 5'd0, rt_IF_ID = 5'd0, rd_ID = 5'd0;
    logic [1:0]  tuse_rs = 2'd3, tuse_rt = 2'd3, tnew_ID = 2'd0;
    logic        we_ID = 1'b0;
    logic [4:0]  rd_ID_EX, rd_EX_MEM, rd_MEM_WB;
    logic        we_ID_EX, we_EX_MEM, we_MEM_WB;
    logic        stall, bubble;
    logic [31:0] stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       tag;
        logic        stall;
        logic [31:0] cnt;
        logic [4:0]  ri;
        logic        wi;
        logic [4:0]  re;
        logic        we;
        logic [4:0]  rm;
        logic        wm;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    hazard_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .rs_IF_ID  (rs_IF_ID),
        .rt_IF_ID  (rt_IF_ID),
        .tuse_rs   (tuse_rs),
        .tuse_rt   (tuse_rt),
        .rd_ID     (rd_ID),
        .we_ID     (we_ID),
        .tnew_ID   (tnew_ID),
        .rd_ID_EX  (rd_ID_EX),
        .rd_EX_MEM (rd_EX_MEM),
        .rd_MEM_WB (rd_MEM_WB),
        .we_ID_EX  (we_ID_EX),
        .we_EX_MEM (we_EX_MEM),
        .we_MEM_WB (we_MEM_WB),
        .stall     (stall),
        .bubble    (bubble),
        .stall_cnt (stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one decode cycle at negedge, queue the expectation, check 1 ns later.
    task automatic step(input string tag, input logic rst,
                        input logic [4:0] rs, input logic [1:0] tu_rs,
                        input logic [4:0] rt, input logic [1:0] tu_rt,
                        input logic [4:0] rd, input logic we, input logic [1:0] tn,
                        input logic e_stall, input logic [31:0] e_cnt,
                        input logic [4:0] e_ri, input logic e_wi,
                        input logic [4:0] e_re, input logic e_we,
                        input logic [4:0] e_rm, input logic e_wm);
        exp_t e;
        exp_t g;
        @(negedge clk);
        reset = rst;
        rs_IF_ID = rs; tuse_rs = tu_rs;
        rt_IF_ID = rt; tuse_rt = tu_rt;
        rd_ID = rd; we_ID = we; tnew_ID = tn;
        e.tag = tag; e.stall = e_stall; e.cnt = e_cnt;
        e.ri = e_ri; e.wi = e_wi; e.re = e_re; e.we = e_we; e.rm = e_rm; e.wm = e_wm;
        sb.push_back(e);
        #1;
        g = sb.pop_front();
        check({g.tag, ".stall"},     {31'd0, stall},     {31'd0, g.stall});
        check({g.tag, ".bubble"},    {31'd0, bubble},    {31'd0, g.stall});
        check({g.tag, ".stall_cnt"}, stall_cnt,          g.cnt);
        check({g.tag, ".rd_ID_EX"},  {27'd0, rd_ID_EX},  {27'd0, g.ri});
        check({g.tag, ".we_ID_EX"},  {31'd0, we_ID_EX},  {31'd0, g.wi});
        check({g.tag, ".rd_EX_MEM"}, {27'd0, rd_EX_MEM}, {27'd0, g.re});
        check({g.tag, ".we_EX_MEM"}, {31'd0, we_EX_MEM}, {31'd0, g.we});
        check({g.tag, ".rd_MEM_WB"}, {27'd0, rd_MEM_WB}, {27'd0, g.rm});
        check({g.tag, ".we_MEM_WB"}, {31'd0, we_MEM_WB}, {31'd0, g.wm});
    endtask

    initial begin
        //     tag           rst rs tu rt tu rd we tn  stl cnt         ri wi re we rm wm
        step("rst0",        1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 1'b0, 32'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        // load-use: lw $8 then rs=8 with tuse 1
        step("lu_lw",       1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd8, 1'b1, 2'd2, 1'b0, 32'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        step("lu_stall",    1'b0, 5'd8, 2'd1, 5'd0, 2'd3, 5'd9, 1'b1, 2'd1, 1'b1, 32'd0, 5'd8, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        step("lu_go",       1'b0, 5'd8, 2'd1, 5'd0, 2'd3, 5'd9, 1'b1, 2'd1, 1'b0, 32'd1, 5'd0, 1'b0, 5'd8, 1'b1, 5'd0, 1'b0);
        // branch after ALU: addu $3 then beq rs=3 tuse 0
        step("alu_addu",    1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd3, 1'b1, 2'd1, 1'b0, 32'd1, 5'd9, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1);
        step("alu_beq",     1'b0, 5'd3, 2'd0, 5'd4, 2'd0, 5'd0, 1'b0, 2'd0, 1'b1, 32'd1, 5'd3, 1'b1, 5'd9, 1'b1, 5'd0, 1'b0);
        step("alu_go",      1'b0, 5'd3, 2'd0, 5'd4, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0, 32'd2, 5'd0, 1'b0, 5'd3, 1'b1, 5'd9, 1'b1);
        step("rst_mid",     1'b1, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 1'b0, 32'd2, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1);
        // branch after load: lw $5 then beq rt=5 tuse 0 -> two stalls
        step("ld_lw",       1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd5, 1'b1, 2'd2, 1'b0, 32'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        step("ld_beq1",     1'b0, 5'd7, 2'd0, 5'd5, 2'd0, 5'd0, 1'b0, 2'd0, 1'b1, 32'd0, 5'd5, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        step("ld_beq2",     1'b0, 5'd7, 2'd0, 5'd5, 2'd0, 5'd0, 1'b0, 2'd0, 1'b1, 32'd1, 5'd0, 1'b0, 5'd5, 1'b1, 5'd0, 1'b0);
        step("ld_go",       1'b0, 5'd7, 2'd0, 5'd5, 2'd0, 5'd0, 1'b0, 2'd0, 1'b0, 32'd2, 5'd0, 1'b0, 5'd0, 1'b0, 5'd5, 1'b1);
        // store data: lw $6 then sw rt=6 tuse 2 -> no stall
        step("sw_lw",       1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd6, 1'b1, 2'd2, 1'b0, 32'd2, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        step("sw_data",     1'b0, 5'd29, 2'd1, 5'd6, 2'd2, 5'd0, 1'b0, 2'd0, 1'b0, 32'd2, 5'd6, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        step("sw_fwd",      1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 1'b0, 32'd2, 5'd0, 1'b0, 5'd6, 1'b1, 5'd0, 1'b0);
        // $0 destination never creates a writer
        step("z_lw0",       1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b1, 2'd2, 1'b0, 32'd2, 5'd0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b1);
        step("z_use0",      1'b0, 5'd0, 2'd1, 5'd0, 2'd3, 5'd10, 1'b1, 2'd1, 1'b0, 32'd2, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        step("tuse_none",   1'b0, 5'd10, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 1'b0, 32'd2, 5'd10, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        // simultaneous rs and rt hazard, then reset in the middle of the stall
        step("dual_lw",     1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd11, 1'b1, 2'd2, 1'b0, 32'd2, 5'd0, 1'b0, 5'd10, 1'b1, 5'd0, 1'b0);
        step("dual_stall",  1'b0, 5'd11, 2'd1, 5'd11, 2'd0, 5'd12, 1'b1, 2'd1, 1'b1, 32'd2, 5'd11, 1'b1, 5'd0, 1'b0, 5'd10, 1'b1);
        step("rst_stall",   1'b1, 5'd11, 2'd1, 5'd11, 2'd0, 5'd12, 1'b1, 2'd1, 1'b0, 32'd3, 5'd0, 1'b0, 5'd11, 1'b1, 5'd0, 1'b0);
        step("rst_after",   1'b0, 5'd11, 2'd1, 5'd11, 2'd0, 5'd12, 1'b1, 2'd1, 1'b0, 32'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
        // counter wrap: preload all-ones, one stall cycle takes it to zero
        #1 force dut.stall_cnt_q = 32'hFFFF_FFFF;
        #1 release dut.stall_cnt_q;
        step("wrap",        1'b0, 5'd12, 2'd0, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 1'b1, 32'hFFFF_FFFF, 5'd12, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0);
        step("wrap_done",   1'b0, 5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 1'b0, 2'd0, 1'b0, 32'd0, 5'd0, 1'b0, 5'd12, 1'b1, 5'd0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
